// File: rtl/spad_pkg.sv
// Shared types, widths and pointer arithmetic for the ring scratchpad.
package spad_pkg;

  localparam int SPAD_DATA_W = 8;
  localparam int SPAD_DEPTH  = 16;
  localparam int SPAD_PTR_W  = $clog2(SPAD_DEPTH);
  localparam int SPAD_CNT_W  = $clog2(SPAD_DEPTH) + 1;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [SPAD_DATA_W-1:0] data;
  } spad_rd_rsp_t;

  function automatic int unsigned ptr_wrap(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned depth);
    return (ptr + inc) % depth;
  endfunction

endpackage

// File: rtl/spad_ring_ptr.sv
// Wrapping ring pointer with a variable per-cycle increment; used for head and tail.
module spad_ring_ptr
  import spad_pkg::*;
#(
  parameter int DEPTH = SPAD_DEPTH,
  parameter int INC_W = 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     clear,
  input  logic                     adv,
  input  logic [INC_W-1:0]         inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] ptr_nxt;

  assign ptr_nxt = PTR_W'(ptr_wrap(32'(ptr), 32'(inc), unsigned'(DEPTH)));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/ring_spad.sv
// Circular operand scratchpad: tail-append push, head-relative registered read, strided pop.
// Optional rd_is_zero output is built only when RING_SPAD_ZERO_FLAG_EN is defined.
module ring_spad
  import spad_pkg::*;
#(
  parameter int dataSize    = SPAD_DATA_W,
  parameter int numRegister = SPAD_DEPTH,
  parameter int maxStride   = 4
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             clear,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [dataSize-1:0]              wr_data,
  input  logic                             rd_en,
  input  logic [$clog2(numRegister)-1:0]   rd_offset,
  output logic                             rd_valid,
  output logic [dataSize-1:0]              rd_data,
  output logic                             rd_err,
  input  logic                             pop_en,
  input  logic [$clog2(maxStride+1)-1:0]   pop_num,
  output logic [$clog2(numRegister):0]     count,
`ifdef RING_SPAD_ZERO_FLAG_EN
  output logic                             rd_is_zero,
`endif
  output logic                             empty
);

  localparam int PTR_W = $clog2(numRegister);
  localparam int CNT_W = PTR_W + 1;

  logic [dataSize-1:0] mem [numRegister];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic                push;
  logic [CNT_W-1:0]    pop_req;
  logic [CNT_W-1:0]    popped;
  logic [PTR_W-1:0]    rd_addr;
  logic                rd_oob;
  logic [dataSize-1:0] rd_word;

  // Both wr_ready and popped look at the pre-update count, so a pop never makes room for a push.
  assign wr_ready = (count < CNT_W'(numRegister));
  assign empty    = (count == '0);
  assign push     = wr_valid && wr_ready;
  assign pop_req  = pop_en ? CNT_W'(pop_num) : '0;
  assign popped   = (pop_req > count) ? count : pop_req;

  assign rd_addr  = head + rd_offset;
  assign rd_oob   = ({1'b0, rd_offset} >= count);
  assign rd_word  = mem[rd_addr];

  spad_ring_ptr #(.DEPTH(numRegister), .INC_W(CNT_W)) u_head (
    .clk   (clk),
    .nrst  (nrst),
    .clear (clear),
    .adv   (1'b1),
    .inc   (popped),
    .ptr   (head)
  );

  spad_ring_ptr #(.DEPTH(numRegister), .INC_W(1)) u_tail (
    .clk   (clk),
    .nrst  (nrst),
    .clear (clear),
    .adv   (push),
    .inc   (1'b1),
    .ptr   (tail)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(push) - popped;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < numRegister; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[tail] <= wr_data;
    end
  end

  // Read response is taken from the pre-cycle state, including in a clear cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && rd_oob;
      if (rd_en) rd_data <= rd_oob ? '0 : rd_word;
    end
  end

`ifdef RING_SPAD_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_is_zero <= 1'b0;
    end else begin
      rd_is_zero <= rd_en && (rd_oob || (rd_word == '0));
    end
  end
`endif

endmodule

// File: tb/tb_ring_spad.sv
// Directed self-checking bench for ring_spad (covers rd_is_zero when RING_SPAD_ZERO_FLAG_EN is defined).
module tb_ring_spad;

  logic       clk;
  logic       nrst;
  logic       clear;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_offset;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       pop_en;
  logic [2:0] pop_num;
  logic [4:0] count;
  logic       empty;
`ifdef RING_SPAD_ZERO_FLAG_EN
  logic       rd_is_zero;
`endif

  int n_asserts = 0;
  int n_fails   = 0;

  ring_spad #(.dataSize(8), .numRegister(16), .maxStride(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .clear      (clear),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_offset  (rd_offset),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .pop_en     (pop_en),
    .pop_num    (pop_num),
    .count      (count),
`ifdef RING_SPAD_ZERO_FLAG_EN
    .rd_is_zero (rd_is_zero),
`endif
    .empty      (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pop(input logic [2:0] n);
    pop_en  = 1'b1;
    pop_num = n;
    step();
    pop_en  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] off);
    rd_en     = 1'b1;
    rd_offset = off;
    step();
    rd_en     = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_offset = '0; pop_en = 1'b0; pop_num = '0;
    #12;
    check("rst_count",    32'(count),    32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_rd_err",   32'(rd_err),   32'd0);
    nrst = 1'b1;

    // fill to 15, then 16, then a rejected 17th
    for (int i = 0; i < 15; i++) push(8'(8'h11 + i));
    check("fill15_count",    32'(count),    32'd15);
    check("fill15_wr_ready", 32'(wr_ready), 32'd1);
    push(8'h20);
    check("full_count",    32'(count),    32'd16);
    check("full_wr_ready", 32'(wr_ready), 32'd0);
    check("full_empty",    32'(empty),    32'd0);
    push(8'h21);
    check("over_count", 32'(count), 32'd16);
    rd(4'd0);
    check("over_no_write", 32'(rd_data), 32'h11);

    rd(4'd5);
    check("rd5_valid", 32'(rd_valid), 32'd1);
    check("rd5_data",  32'(rd_data),  32'h16);
    check("rd5_err",   32'(rd_err),   32'd0);
    step();
    check("idle_valid", 32'(rd_valid), 32'd0);
    check("idle_hold",  32'(rd_data),  32'h16);

    pop(3'd4);
    check("pop4_count", 32'(count), 32'd12);
    rd(4'd0);
    check("pop4_rd0", 32'(rd_data), 32'h15);

    // head ends at 12; the 8 new pushes wrap the tail to physical 0..7
    do_clear();
    check("clr_count", 32'(count), 32'd0);
    for (int i = 0; i < 16; i++) push(8'(8'h50 + i));
    pop(3'd4); pop(3'd4); pop(3'd4);
    check("pop12_count", 32'(count), 32'd4);
    for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
    check("wrap_count", 32'(count), 32'd12);
    rd(4'd11);
    check("wrap_rd11", 32'(rd_data), 32'h67);
    rd(4'd3);
    check("wrap_rd3", 32'(rd_data), 32'h5F);

    for (int i = 0; i < 4; i++) push(8'(8'h70 + i));
    check("refull_count", 32'(count), 32'd16);
    wr_valid = 1'b1; wr_data = 8'hAA; pop_en = 1'b1; pop_num = 3'd2;
    step();
    pop_en = 1'b0;
    check("pushpop_count",    32'(count),    32'd14);
    check("pushpop_wr_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    check("retry_count", 32'(count), 32'd15);
    rd(4'd14);
    check("retry_data", 32'(rd_data), 32'hAA);

    // read of the slot being pushed this cycle is out of range
    wr_valid = 1'b1; wr_data = 8'hBB; rd_en = 1'b1; rd_offset = 4'd15;
    step();
    wr_valid = 1'b0; rd_en = 1'b0;
    check("rdpush_err",   32'(rd_err),   32'd1);
    check("rdpush_data",  32'(rd_data),  32'd0);
    check("rdpush_count", 32'(count),    32'd16);

    do_clear();
    push(8'h81); push(8'h82); push(8'h83);
    rd(4'd3);
    check("oob_valid", 32'(rd_valid), 32'd1);
    check("oob_err",   32'(rd_err),   32'd1);
    check("oob_data",  32'(rd_data),  32'd0);
    rd(4'd2);
    check("inb_err",  32'(rd_err),  32'd0);
    check("inb_data", 32'(rd_data), 32'h83);
    pop(3'd0);
    check("pop0_count", 32'(count), 32'd3);
    pop_num = 3'd4;
    step();
    check("popoff_count", 32'(count), 32'd3);
    pop(3'd4);
    check("popall_count", 32'(count), 32'd0);
    check("popall_empty", 32'(empty), 32'd1);

    wr_valid = 1'b1; wr_data = 8'h99; clear = 1'b1;
    step();
    wr_valid = 1'b0; clear = 1'b0;
    check("clrpush_count", 32'(count), 32'd0);
    check("clrpush_empty", 32'(empty), 32'd1);

    push(8'h91); push(8'h92);
    clear = 1'b1; rd_en = 1'b1; rd_offset = 4'd1;
    step();
    clear = 1'b0; rd_en = 1'b0;
    check("clrrd_data",  32'(rd_data), 32'h92);
    check("clrrd_err",   32'(rd_err),  32'd0);
    check("clrrd_count", 32'(count),   32'd0);

`ifdef RING_SPAD_ZERO_FLAG_EN
    push(8'h00); push(8'h5A);
    rd(4'd0);
    check("zf_zero", 32'(rd_is_zero), 32'd1);
    rd(4'd1);
    check("zf_nonzero", 32'(rd_is_zero), 32'd0);
    do_clear();
`endif

    push(8'hC3);
    rd_en = 1'b1; rd_offset = 4'd0;
    step();
    check("pre_abort_data", 32'(rd_data), 32'hC3);
    #2 nrst = 1'b0;
    #1;
    check("abort_valid", 32'(rd_valid), 32'd0);
    check("abort_count", 32'(count),    32'd0);
    rd_en = 1'b0;
    #2 nrst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
